mesh_ingress: RTL and testbench
===============================

# mesh_ingress

Parametrised west-edge ingress stage for the compute mesh. Latches a per-row configuration word and a per-row skew on a load command, then accepts one column of row data per beat over a valid/ready handshake. Each row is delayed by its programmed skew so the mesh sees systolically staggered operands. Drives per-row configuration, data and valid into the first switch column, and pulses `done` once the last beat has left every row.

## Interface
- `ROWS`, 4, number of mesh rows / output channels
- `DATA_W`, 32, data word width
- `CONF_W`, 64, per-row configuration word width
- `MAX_SKEW`, 8, skew line depth; legal skew 0..MAX_SKEW-1
- `LEN_W`, 16, stream length counter width
- `clk` in 1: single clock, all logic rising-edge
- `reset` in 1: asynchronous, active-low; clears all state
- `cfg_load` in 1: latch `cfg_conf`/`cfg_skew`; honoured only in IDLE
- `cfg_conf` in ROWS×CONF_W: per-row configuration words
- `cfg_skew` in ROWS×$clog2(MAX_SKEW): per-row delay in beats
- `start` in 1: begin stream; honoured only in IDLE
- `len` in LEN_W: beats in stream, sampled with `start`
- `flush` in 1: synchronous abort to IDLE
- `in_valid` in 1, `in_ready` out 1, `in_data` in ROWS×DATA_W: column beat handshake
- `out_ready` in 1: global mesh advance enable
- `out_valid` out ROWS, `out_data` out ROWS×DATA_W: per-row west-edge outputs
- `conf_out` out ROWS×CONF_W: registered configuration to switches
- `busy` out 1: state != IDLE
- `done` out 1: one-cycle completion pulse

## Operation
- FSM: IDLE, STREAM, DRAIN, DONE.
- IDLE: `cfg_load` latches `conf_out` and the skew registers. Out-of-range skew is not possible given the field width. `start` with `len`>0 -> STREAM, with `len`==0 -> DONE. `cfg_load` and `start` in the same cycle: config is latched first, and the stream uses the new config.
- `cfg_load`/`start` outside IDLE are ignored; `conf_out` and skews are stable while `busy`.
- STREAM: `in_ready` = `out_ready`. A beat is accepted on `in_valid && in_ready` and decrements the remaining count. Acceptance of the final beat -> DRAIN; the drain counter is loaded with max(programmed skew).
- Advance occurs on every STREAM/DRAIN cycle with `out_ready`=1. All row skew lines shift together. A cycle with `in_valid`=0 inserts a bubble. `out_ready`=0 freezes every line, output and counter.
- Each row has a MAX_SKEW-slot shift line with a data/valid tag per slot. Row r taps slot `skew[r]`, then feeds a registered output stage.
- DRAIN: the counter decrements on advance. At 0, and once the output stage has advanced, -> DONE.
- DONE: `done`=1 for one cycle, -> IDLE. `in_ready`=0 outside STREAM.
- `flush` (any state) empties lines and clears `out_valid`, returns to IDLE with no `done`, and keeps the config.
- `flush` beats `start` in the same cycle.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `conf_out`=0, skews=0, `in_ready`=0, `busy`=0, `done`=0, state IDLE.
- `conf_out` updates the cycle after `cfg_load`.
- A beat accepted at edge t appears on row r at edge t+1+skew[r], given `out_ready` held high. Each low `out_ready` cycle adds one cycle.
- `done` asserts 1+max(skew)+1 advancing cycles after the final beat is accepted. With `len`=0, `done` asserts the cycle after `start`.
- Async reset mid-stream drops all in-flight data immediately, with no `done`.

## Configuration
- `MESH_INGRESS_ZEROPAD_EN` defined: during STREAM/DRAIN every advancing cycle drives `out_valid[r]`=1 on all rows. Slots with no real data (skew fill, bubbles, drain) output `out_data[r]`=0, giving the mesh a dense zero-padded wavefront.
- Undefined: `out_valid[r]`=1 only for real data. Empty slots give `out_valid[r]`=0 and `out_data[r]` holding its last value.

## Test plan
- Reset/config: assert `reset`=0 mid-stream -> all outputs 0, `busy`=0. Then `cfg_load` with conf row i = 64'hA0+i -> `conf_out` matches the next cycle.
- Skew: skews {0,1,2,3}, `len`=4, `in_data` row r beat k = 16·r+k, `out_ready`=1 -> row r emits beats 0..3 starting at cycle 1+r after the first accept; `done` pulses 5 cycles after the last accept.
- Backpressure: same stream with `out_ready` low for 2 cycles mid-stream -> `in_ready`=0 during the stall, data frozen, every timing shifts by exactly 2, no loss or duplication.
- Bubbles: `len`=3 with `in_valid` low for 1 cycle between beats -> the gap propagates per row. Zero-pad build emits valid zero; default build emits `out_valid`=0.
- Boundaries: `start` with `len`=0 -> `done` the next cycle. `cfg_load`+`start` in the same cycle uses the new skews. `cfg_load` while busy leaves `conf_out` unchanged.
- Flush: `flush` during DRAIN -> IDLE the next cycle, `out_valid`=0, no `done`, config retained.

Source files
------------

// File: rtl/mesh_ingress.sv
// mesh_ingress: west-edge ingress for the compute mesh. It delays each row by a programmed skew
// so the mesh sees staggered operands. Define MESH_INGRESS_ZEROPAD_EN to fill empty slots with valid zeros.
module mesh_ingress #(
  parameter  int unsigned ROWS     = 4,
  parameter  int unsigned DATA_W   = 32,
  parameter  int unsigned CONF_W   = 64,
  parameter  int unsigned MAX_SKEW = 8,
  parameter  int unsigned LEN_W    = 16,
  localparam int unsigned SKEW_W   = $clog2(MAX_SKEW)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_load,
  input  logic [ROWS-1:0][CONF_W-1:0]   cfg_conf,
  input  logic [ROWS-1:0][SKEW_W-1:0]   cfg_skew,
  input  logic                          start,
  input  logic [LEN_W-1:0]              len,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS-1:0][DATA_W-1:0]   in_data,
  input  logic                          out_ready,
  output logic [ROWS-1:0]               out_valid,
  output logic [ROWS-1:0][DATA_W-1:0]   out_data,
  output logic [ROWS-1:0][CONF_W-1:0]   conf_out,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned DRAIN_W = SKEW_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                                r_state, w_state_nxt;
  logic [LEN_W-1:0]                      r_remain, w_remain_nxt;
  logic [DRAIN_W-1:0]                    r_drain, w_drain_nxt;
  logic [ROWS-1:0][CONF_W-1:0]           r_conf;
  logic [ROWS-1:0][SKEW_W-1:0]           r_skew;
  logic                                  r_done;
  logic [ROWS-1:0][MAX_SKEW-1:0]         r_line_vld;
  logic [ROWS-1:0][MAX_SKEW-1:0][DATA_W-1:0] r_line_data;
  logic [ROWS-1:0]                       r_out_valid;
  logic [ROWS-1:0][DATA_W-1:0]           r_out_data;

  logic                                  w_load_cfg;
  logic                                  w_adv;
  logic                                  w_accept;
  logic [SKEW_W-1:0]                     w_skew_max;
  logic [ROWS-1:0]                       w_tap_vld;
  logic [ROWS-1:0][DATA_W-1:0]           w_tap_data;

  assign in_ready  = (r_state == S_STREAM) && out_ready;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign conf_out  = r_conf;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Deepest programmed skew sets the drain length
  always_comb begin
    w_skew_max = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (r_skew[r] > w_skew_max) w_skew_max = r_skew[r];
    end
  end

  always_comb begin
    w_tap_vld  = '0;
    w_tap_data = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      w_tap_vld[r]  = r_line_vld[r][r_skew[r]];
      w_tap_data[r] = r_line_data[r][r_skew[r]];
    end
  end

  // Next-state and control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_drain_nxt  = r_drain;
    w_load_cfg   = 1'b0;
    w_adv        = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load_cfg = cfg_load;
        if (start) begin
          w_remain_nxt = len;
          w_state_nxt  = (len == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        w_adv    = out_ready;
        w_accept = in_valid && out_ready;
        if (w_accept) begin
          if (r_remain == LEN_W'(1)) begin
            w_state_nxt = S_DRAIN;
            // one extra advance lets the deepest row's output stage move past the last beat
            w_drain_nxt = DRAIN_W'(w_skew_max) + DRAIN_W'(1);
          end
          w_remain_nxt = r_remain - LEN_W'(1);
        end
      end
      S_DRAIN: begin
        w_adv = out_ready;
        if (out_ready) begin
          if (r_drain == '0) w_state_nxt = S_DONE;
          else               w_drain_nxt = r_drain - DRAIN_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_load_cfg  = 1'b0;
      w_adv       = 1'b0;
      w_accept    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_remain <= '0;
      r_drain  <= '0;
      r_conf   <= '0;
      r_skew   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
      r_drain  <= w_drain_nxt;
      r_done   <= (w_state_nxt == S_DONE);
      if (w_load_cfg) begin
        r_conf <= cfg_conf;
        r_skew <= cfg_skew;
      end
    end
  end

  // Skew lines; emptied in IDLE so a new skew never taps a stale slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_line_vld  <= '0;
      r_line_data <= '0;
    end else if (flush || (r_state == S_IDLE)) begin
      r_line_vld <= '0;
    end else if (w_adv) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        r_line_vld[r][0]  <= w_accept;
        r_line_data[r][0] <= in_data[r];
        for (int k = 1; k < int'(MAX_SKEW); k++) begin
          r_line_vld[r][k]  <= r_line_vld[r][k-1];
          r_line_data[r][k] <= r_line_data[r][k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= '0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_out_valid <= '0;
    end else if (w_adv) begin
      for (int r = 0; r < int'(ROWS); r++) begin
`ifdef MESH_INGRESS_ZEROPAD_EN
        r_out_valid[r] <= 1'b1;
        r_out_data[r]  <= w_tap_vld[r] ? w_tap_data[r] : '0;
`else
        r_out_valid[r] <= w_tap_vld[r];
        if (w_tap_vld[r]) r_out_data[r] <= w_tap_data[r];
`endif
      end
    end else if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
      r_out_valid <= '0;
    end
  end

endmodule

// File: tb/tb_mesh_ingress.sv
// Scoreboard bench for mesh_ingress: the stimulus pushes the expected per-row beats and their arrival cycles.
// A negedge monitor pops them and compares data and arrival cycle.
`timescale 1ns/1ps
module tb_mesh_ingress;
  localparam int unsigned ROWS = 4, DATA_W = 32, CONF_W = 64, MAX_SKEW = 8, LEN_W = 16, SKEW_W = 3;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        cfg_load;
  logic [ROWS-1:0][CONF_W-1:0] cfg_conf;
  logic [ROWS-1:0][SKEW_W-1:0] cfg_skew;
  logic                        start;
  logic [LEN_W-1:0]            len;
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [ROWS-1:0][DATA_W-1:0] in_data;
  logic                        out_ready;
  logic [ROWS-1:0]             out_valid;
  logic [ROWS-1:0][DATA_W-1:0] out_data;
  logic [ROWS-1:0][CONF_W-1:0] conf_out;
  logic                        busy;
  logic                        done;

  mesh_ingress #(.ROWS(ROWS), .DATA_W(DATA_W), .CONF_W(CONF_W), .MAX_SKEW(MAX_SKEW), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_conf(cfg_conf), .cfg_skew(cfg_skew),
    .start(start), .len(len), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .conf_out(conf_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [DATA_W-1:0] data; int cyc; } exp_t;
  exp_t exp_q[ROWS][$];
  bit   seen[ROWS];
  int   sk[ROWS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: first sighting of a beat checks its arrival cycle, every sighting checks data
  always @(negedge clk) begin
    if (reset) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        if (out_valid[r]) begin
          if (exp_q[r].size() == 0 || (!seen[r] && exp_q[r][0].cyc > cyc)) begin
`ifdef MESH_INGRESS_ZEROPAD_EN
            chk($sformatf("pad_data_r%0d", r), 64'(out_data[r]), 64'd0);
`else
            chk($sformatf("unexpected_valid_r%0d", r), 64'(out_valid[r]), 64'd0);
`endif
          end else begin
            if (!seen[r]) chk($sformatf("arrival_cycle_r%0d", r), 64'(cyc), 64'(exp_q[r][0].cyc));
            chk($sformatf("beat_data_r%0d", r), 64'(out_data[r]), 64'(exp_q[r][0].data));
            if (out_ready) begin
              void'(exp_q[r].pop_front());
              seen[r] = 1'b0;
            end else begin
              seen[r] = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic set_cfg(input logic [63:0] conf_base, input int s0, input int s1, input int s2, input int s3);
    sk[0] = s0; sk[1] = s1; sk[2] = s2; sk[3] = s3;
    for (int r = 0; r < int'(ROWS); r++) begin
      cfg_conf[r] = conf_base + 64'(r);
      cfg_skew[r] = SKEW_W'(sk[r]);
    end
    cfg_load = 1'b1;
  endtask

  task automatic check_queues(input string tag);
    for (int r = 0; r < int'(ROWS); r++)
      chk($sformatf("%s_leftover_r%0d", tag, r), 64'(exp_q[r].size()), 64'd0);
  endtask

  // Stream driver: vpat/rpat give in_valid/out_ready per cycle, done_off is the hand-computed done delay
  task automatic run_stream(input string tag, input int nlen, input logic [63:0] vpat,
                            input logic [63:0] rpat, input int done_off, input logic [DATA_W-1:0] base);
    int k = 0, s_cyc, e_last = -1, done_cyc = -1, ndone = 0, j, cnt;
    exp_t e;
    start = 1'b1; len = LEN_W'(nlen);
    @(posedge clk); #1;
    start = 1'b0; cfg_load = 1'b0; s_cyc = cyc;
    for (int i = 0; i < 40; i++) begin
      in_valid  = vpat[i] && (k < nlen);
      out_ready = rpat[i];
      for (int r = 0; r < int'(ROWS); r++) in_data[r] = base + DATA_W'(16 * r + k);
      @(negedge clk);
      chk($sformatf("%s_in_ready", tag), 64'(in_ready), (k < nlen) ? 64'(rpat[i]) : 64'd0);
      @(posedge clk); #1;
      if (in_valid && out_ready) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          cnt = 0; j = i;
          while (cnt < 1 + sk[r]) begin
            j++;
            if (rpat[j]) cnt++;
          end
          e.data = in_data[r];
          e.cyc  = s_cyc + 1 + j;
          exp_q[r].push_back(e);
        end
        k++;
        if (k == nlen) e_last = cyc;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk($sformatf("%s_done_count", tag), 64'(ndone), 64'd1);
    chk($sformatf("%s_done_offset", tag), 64'(done_cyc - e_last), 64'(done_off));
    chk($sformatf("%s_busy_after", tag), 64'(busy), 64'd0);
    check_queues(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int nd;
    reset = 1'b0; cfg_load = 1'b0; cfg_conf = '0; cfg_skew = '0; start = 1'b0; len = '0;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int r = 0; r < int'(ROWS); r++) sk[r] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data[0] | out_data[1] | out_data[2] | out_data[3]), 64'd0);
    chk("rst_conf_out", conf_out[0] | conf_out[1] | conf_out[2] | conf_out[3], 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Config load: conf row i = A0+i, skews 0..3
    set_cfg(64'hA0, 0, 1, 2, 3);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    for (int r = 0; r < int'(ROWS); r++) chk($sformatf("cfg_conf_out_r%0d", r), conf_out[r], 64'hA0 + 64'(r));

    // Skew staircase, then backpressure, then bubbles
    run_stream("skew", 4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5, 32'h0);
    run_stream("stall", 4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF3, 5, 32'h40);
    run_stream("bubble", 3, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 5, 32'h80);

    // len=0 gives done next cycle; cfg_load while busy is ignored
    start = 1'b1; len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_busy", 64'(busy), 64'd1);
    for (int r = 0; r < int'(ROWS); r++) cfg_conf[r] = 64'hDEAD_0000 + 64'(r);
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    chk("len0_done_clear", 64'(done), 64'd0);
    chk("len0_idle", 64'(busy), 64'd0);
    for (int r = 0; r < int'(ROWS); r++) chk($sformatf("busy_cfg_kept_r%0d", r), conf_out[r], 64'hA0 + 64'(r));

    // cfg_load with start: the stream uses the new skews (max 2 -> done 4 after last beat)
    @(posedge clk); #1;
    set_cfg(64'hB0, 2, 0, 1, 2);
    run_stream("cfgstart", 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4, 32'h100);
    for (int r = 0; r < int'(ROWS); r++) chk($sformatf("new_conf_r%0d", r), conf_out[r], 64'hB0 + 64'(r));

    // Flush during DRAIN: only the skew-0 row gets its beat out before the flush
    start = 1'b1; len = LEN_W'(1);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    for (int r = 0; r < int'(ROWS); r++) in_data[r] = 32'h200 + DATA_W'(r);
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin
      exp_t e;
      e.data = 32'h201; e.cyc = cyc + 1;
      exp_q[1].push_back(e);
    end
    @(posedge clk); #1;
    chk("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    nd = int'(done);
    repeat (8) begin
      @(posedge clk); #1;
      nd += int'(done);
    end
    chk("flush_no_done", 64'(nd), 64'd0);
    chk("flush_conf_kept", conf_out[3], 64'hB3);
    check_queues("flush");

    // Async reset mid-stream drops everything at once
    start = 1'b1; len = LEN_W'(4);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data[0] | out_data[1] | out_data[2] | out_data[3]), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_conf_out", conf_out[1], 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
